max_finder: RTL
===============

# max_finder

Final classification stage of the MLP. Sits directly downstream of the last fully-connected layer. It captures the layer's packed `NN`-wide neuron output vector on that layer's output-valid strobe, then scans it sequentially, one element per clock, for the largest signed value. It reports the winning neuron index, which is the predicted class, as a one-cycle valid pulse.

## Interface
- `NN`, 10, number of neurons in the input vector; must be at least 2.
- `dataWidth`, 16, width of one neuron output, signed two's complement fixed point.
- `idxWidth`, 4, width of the index output; must satisfy 2^idxWidth >= NN.

- `clk`  in  1  the single clock; all state is updated on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_valid`  in  1  input-vector strobe; driven from the layer's `o_valid[0]`.
- `i_data`  in  NN*dataWidth  packed neuron outputs; element k is at `[k*dataWidth +: dataWidth]`.
- `o_valid`  out  1  one-cycle result strobe.
- `o_data`  out  idxWidth  index of the maximum element; holds its value until the next result.
- `o_busy`  out  1  high while a scan is in progress.
- `o_overrun`  out  1  sticky flag: an `i_valid` was dropped while busy.

## Operation
- The block has two states, IDLE and SCAN. Reset puts it in IDLE.
- **Capture (IDLE, `i_valid`=1):**
  - Latch all of `i_data` into an internal buffer.
  - Set `cur_max` = element 0, `cur_idx` = 0, `cnt` = 1.
  - Go to SCAN.
- **SCAN, each cycle:**
  - Compare buffer element `cnt` against `cur_max`, signed.
  - If it is strictly greater, load its value into `cur_max` and `cnt` into `cur_idx`.
  - Increment `cnt`.
- **Finish:** on the SCAN cycle with `cnt`=NN-1:
  - Apply that cycle's compare.
  - At the same edge, register the final index into `o_data`, pulse `o_valid`, and return to IDLE.
- **Ties:** the lowest index wins, because the compare is strict.
- **Signed compare:** 0x8000 is the most negative value and is never preferred over any other value.
- **`i_valid` while in SCAN:** the strobe is ignored, the buffer is unchanged, and `o_overrun` is set to 1. The flag stays set until `rst`.
- `i_data` is sampled only in the capture cycle. Changes to it during SCAN have no effect.
- **Reset mid-scan:** the scan is aborted, no `o_valid` is produced, and all outputs return to their reset values.
- **Reset values:** `o_valid`=0, `o_data`=0, `o_busy`=0, `o_overrun`=0, state IDLE, internal registers 0.

## Timing
- `i_valid` is sampled high in cycle T (the rising edge ending cycle T).
  - `o_busy` is high in cycles T+1 .. T+NN-1.
  - `o_valid` is high in cycle T+NN only, with `o_data` valid from that cycle onward.
- Latency is exactly NN cycles. For NN=10, the result appears 10 cycles after capture.
- Throughput is one vector per NN cycles.
- A new `i_valid` in cycle T+NN, the cycle in which `o_valid` is high, is accepted: the block is already in IDLE.
- `o_busy` is a registered state decode, so there is no combinational path from any input to any output.
- `o_valid` is never high for two consecutive cycles.

## Configuration
- Macro: `MAX_FINDER_VALUE_OUT_EN`.
- **Defined:** adds output port `o_max` (out, `dataWidth`), the winning element's value.
  - Reset value 0.
  - Registered at the same edge as `o_data`, and holds until the next result.
- **Undefined:** port `o_max` is absent.
  - `cur_max` is still used internally.
  - All other behaviour is identical.

## Test plan
All scenarios use NN=10, dataWidth=16.
- **Basic max:** elements 0..9 = 0x0010·k, except element 7 = 0x0400; `i_valid` in cycle 0 -> `o_valid` in cycle 10 only, `o_data`=7, `o_busy` high in cycles 1..9.
- **Tie:** elements 2 and 5 = 0x0300, all others 0x0100 -> `o_data`=2.
- **Negative values:** all elements 0x8000, except element 4 = 0xFFFF and element 9 = 0xFFF0 -> `o_data`=4. With `MAX_FINDER_VALUE_OUT_EN` defined, `o_max`=0xFFFF.
- **Overrun:** `i_valid` in cycle 0 and again in cycle 5 with different data -> first result only, in cycle 10, and `o_overrun`=1 from cycle 6. A further `i_valid` in cycle 10 -> second result in cycle 20.
- **Reset mid-scan:** `i_valid` in cycle 0, `rst` in cycle 4 -> no `o_valid` through cycle 15, `o_data`=0, `o_busy`=0 from cycle 5.

Source files
------------

// File: rtl/max_finder.sv
// Sequential argmax over a captured NN-element signed vector, one element per clock.
// Optional MAX_FINDER_VALUE_OUT_EN adds o_max, the winning element's value.
module max_finder #(
  parameter int NN        = 10,
  parameter int dataWidth = 16,
  parameter int idxWidth  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [idxWidth-1:0]     o_data,
  output logic                    o_busy,
  output logic                    o_overrun
`ifdef MAX_FINDER_VALUE_OUT_EN
  ,
  output logic [dataWidth-1:0]    o_max
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [idxWidth-1:0] LAST = idxWidth'(NN - 1);

  state_t                      r_state;
  logic signed [dataWidth-1:0] r_buf [NN];
  logic signed [dataWidth-1:0] r_cur_max;
  logic [idxWidth-1:0]         r_cur_idx;
  logic [idxWidth-1:0]         r_cnt;

  logic signed [dataWidth-1:0] w_elem;
  logic signed [dataWidth-1:0] w_win_max;
  logic [idxWidth-1:0]         w_win_idx;
  logic                        w_gt;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_elem = '0;
    for (int unsigned k = 0; k < NN; k++) begin
      if (r_cnt == idxWidth'(k)) w_elem = r_buf[k];
    end
    w_gt      = w_elem > r_cur_max;
    w_win_max = w_gt ? w_elem : r_cur_max;
    w_win_idx = w_gt ? r_cnt : r_cur_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cur_max <= '0;
      r_cur_idx <= '0;
      r_cnt     <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
`ifdef MAX_FINDER_VALUE_OUT_EN
      o_max     <= '0;
`endif
      for (int unsigned k = 0; k < NN; k++) r_buf[k] <= '0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            for (int unsigned k = 0; k < NN; k++) begin
              r_buf[k] <= i_data[k*dataWidth +: dataWidth];
            end
            r_cur_max <= i_data[dataWidth-1:0];
            r_cur_idx <= '0;
            r_cnt     <= idxWidth'(1);
            r_state   <= SCAN;
            o_busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (i_valid) o_overrun <= 1'b1;
          r_cur_max <= w_win_max;
          r_cur_idx <= w_win_idx;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            o_data  <= w_win_idx;
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= IDLE;
`ifdef MAX_FINDER_VALUE_OUT_EN
            o_max   <= w_win_max;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
